receive_sd_response: RTL and testbench

- Serial response receiver for the SD card command path; sits directly downstream of the command transmitter on the same SPI-mode link.
- Started once a command frame has finished shifting out; watches the card's data-out line for a response start bit, then captures an R1 (8-bit) or R3/R7 (40-bit) response MSB-first.
- Reports completion, timeout and an R1 error summary to the card-init/read controller.

---
 rtl/sd_pkg.sv | 45 ++++
 rtl/receive_sd_response.sv | 136 +++++++++++++
 tb/tb_receive_sd_response.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_pkg
// Brief    : Shared constants for the SD command-path response receiver:
//            FSM encoding, response lengths, NCR default, R1 bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package sd_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_SHIFT      = 2'd2;

  // Response lengths in bits (start bit included)
  localparam int R1_LEN   = 8;
  localparam int LONG_LEN = 40;

  // Default number of cycles to wait for a start bit (8 byte times)
  localparam int NCR_MAX_DEFAULT = 64;

  // R1 status bit positions
  localparam int R1_IDLE          = 0;
  localparam int R1_ERASE_RESET   = 1;
  localparam int R1_ILLEGAL_CMD   = 2;
  localparam int R1_CRC_ERR       = 3;
  localparam int R1_ERASE_SEQ_ERR = 4;
  localparam int R1_ADDR_ERR      = 5;
  localparam int R1_PARAM_ERR     = 6;

  // Insert one received bit as the new LSB. Short responses only ever use
  // the low byte so the upper bits are forced to zero.
  function automatic logic [LONG_LEN-1:0] shift_in(
    input logic [LONG_LEN-1:0] cur,
    input logic                is_long,
    input logic                b
  );
    if (is_long) begin
      return {cur[LONG_LEN-2:0], b};
    end
    return {{(LONG_LEN-R1_LEN){1'b0}}, cur[R1_LEN-2:0], b};
  endfunction

endpackage : sd_pkg
`default_nettype wire

// File: rtl/receive_sd_response.sv
`default_nettype none
// ============================================================================
// Module   : receive_sd_response
// Brief    : SPI-mode SD response receiver. After a command has been sent,
//            waits up to NCR_MAX cycles for a start bit on SDin, then
//            captures an R1 (8-bit) or R3/R7 (40-bit) response MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
module receive_sd_response
  import sd_pkg::*;
#(
  parameter int NCR_MAX = NCR_MAX_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                long_resp,
  input  logic                SDin,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic [LONG_LEN-1:0] response,
  output logic [7:0]          r1,
  output logic                r1_error
);

  localparam int               BIT_CNT_W = 6;
  localparam logic [CNT_W-1:0] NCR_LAST  = CNT_W'(NCR_MAX - 1);

  logic [1:0]           state_q,    state_d;
  logic                 mode_long_q, mode_long_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [LONG_LEN-1:0]  response_q, response_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 timeout_q,  timeout_d;

  // Next-state logic: start-bit hunt with timeout, then bit-counted shift
  always_comb begin
    state_d     = state_q;
    mode_long_d = mode_long_q;
    wait_cnt_d  = wait_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    response_d  = response_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_long_d = long_resp;
          response_d  = '0;
          timeout_d   = 1'b0;
          wait_cnt_d  = '0;
          busy_d      = 1'b1;
          state_d     = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (!SDin) begin
          // A low start bit wins even on the edge that would time out
          response_d = shift_in(response_q, mode_long_q, SDin);
          bit_cnt_d  = mode_long_q ? BIT_CNT_W'(LONG_LEN - 1)
                                   : BIT_CNT_W'(R1_LEN - 1);
          state_d    = ST_SHIFT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == NCR_LAST) begin
            response_d = '1;
            timeout_d  = 1'b1;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_SHIFT: begin
        // No framing check: whatever is on SDin is taken as data
        response_d = shift_in(response_q, mode_long_q, SDin);
        bit_cnt_d  = bit_cnt_q - 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(1)) begin
          done_d    = 1'b1;
          timeout_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_long_q <= 1'b0;
      wait_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      response_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_long_q <= mode_long_d;
      wait_cnt_q  <= wait_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      response_q  <= response_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // R1 sits in the top byte of a long response, else in the low byte
  always_comb begin
    r1 = mode_long_q ? response_q[LONG_LEN-1 -: 8] : response_q[7:0];
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign response = response_q;
  assign r1_error = |r1[R1_PARAM_ERR:R1_ERASE_RESET];

endmodule : receive_sd_response
`default_nettype wire

// File: tb/tb_receive_sd_response.sv
`default_nettype none
// ============================================================================
// Module   : tb_receive_sd_response
// Brief    : Directed self-checking bench for receive_sd_response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_receive_sd_response;

  logic        clock;
  logic        reset;
  logic        start;
  logic        long_resp;
  logic        SDin;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [39:0] response;
  logic [7:0]  r1;
  logic        r1_error;

  int n_checks = 0;
  int n_errors = 0;

  receive_sd_response #(.NCR_MAX(64), .CNT_W(7)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .long_resp (long_resp),
    .SDin      (SDin),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .response  (response),
    .r1        (r1),
    .r1_error  (r1_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are observed 1 time unit after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic is_long);
    start     = 1'b1;
    long_resp = is_long;
    tick();
    start     = 1'b0;
    long_resp = 1'b0;
  endtask

  task automatic idle_high(input int n);
    SDin = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Send the first n-1 bits of v (MSB first) without the final one
  task automatic send_head(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 1; i--) begin
      SDin = v[i];
      tick();
    end
  endtask

  task automatic send_last(input logic [39:0] v);
    SDin = v[0];
    tick();
    SDin = 1'b1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; long_resp = 1'b0; SDin = 1'b1;
    #12;
    check("rst_busy",     {39'd0, busy},    40'd0);
    check("rst_done",     {39'd0, done},    40'd0);
    check("rst_timeout",  {39'd0, timeout}, 40'd0);
    check("rst_response", response,         40'd0);
    reset = 1'b1;
    tick();

    // R1, no errors
    do_start(1'b0);
    check("r1_busy_rise", {39'd0, busy}, 40'd1);
    idle_high(3);
    send_head(40'h01, 8);
    check("r1_no_early_done", {39'd0, done}, 40'd0);
    check("r1_busy_mid",      {39'd0, busy}, 40'd1);
    send_last(40'h01);
    check("r1_done",      {39'd0, done},     40'd1);
    check("r1_busy_fall", {39'd0, busy},     40'd0);
    check("r1_response",  response,          40'h01);
    check("r1_byte",      {32'd0, r1},       40'h01);
    check("r1_err",       {39'd0, r1_error}, 40'd0);
    check("r1_timeout",   {39'd0, timeout},  40'd0);
    tick();
    check("r1_done_one_cycle", {39'd0, done}, 40'd0);
    check("r1_hold",           response,      40'h01);

    // R7
    do_start(1'b1);
    idle_high(2);
    send_head(40'h01000001AA, 40);
    check("r7_no_early_done", {39'd0, done}, 40'd0);
    send_last(40'h01000001AA);
    check("r7_done",     {39'd0, done},     40'd1);
    check("r7_response", response,          40'h01000001AA);
    check("r7_r1",       {32'd0, r1},       40'h01);
    check("r7_err",      {39'd0, r1_error}, 40'd0);
    tick();

    // Illegal command
    do_start(1'b0);
    idle_high(1);
    send_head(40'h05, 8);
    send_last(40'h05);
    check("ill_done",     {39'd0, done},     40'd1);
    check("ill_response", response,          40'h05);
    check("ill_r1",       {32'd0, r1},       40'h05);
    check("ill_err",      {39'd0, r1_error}, 40'd1);
    tick();

    // Timeout at E0+64
    do_start(1'b0);
    idle_high(63);
    check("to_no_early", {39'd0, done}, 40'd0);
    check("to_busy_pre", {39'd0, busy}, 40'd1);
    tick();
    check("to_done",     {39'd0, done},    40'd1);
    check("to_flag",     {39'd0, timeout}, 40'd1);
    check("to_busy",     {39'd0, busy},    40'd0);
    check("to_response", response,         40'hFFFFFFFFFF);
    tick();
    check("to_done_low",  {39'd0, done},    40'd0);
    check("to_flag_hold", {39'd0, timeout}, 40'd1);

    // Start bit on the would-be timeout edge
    do_start(1'b0);
    check("to_flag_clear", {39'd0, timeout}, 40'd0);
    idle_high(63);
    SDin = 1'b0;
    tick();
    check("late_sb_no_done", {39'd0, done}, 40'd0);
    check("late_sb_busy",    {39'd0, busy}, 40'd1);
    send_head(40'h03, 7);
    send_last(40'h03);
    check("late_sb_done",     {39'd0, done},    40'd1);
    check("late_sb_timeout",  {39'd0, timeout}, 40'd0);
    check("late_sb_response", response,         40'h03);
    tick();

    // Start while busy and coincident with done are ignored
    do_start(1'b0);
    SDin = 1'b1; start = 1'b1; long_resp = 1'b1;
    tick();
    start = 1'b0; long_resp = 1'b0;
    idle_high(1);
    send_head(40'h01, 8);
    start = 1'b1; long_resp = 1'b1;
    send_last(40'h01);
    start = 1'b0; long_resp = 1'b0;
    check("ign_done",     {39'd0, done}, 40'd1);
    check("ign_busy",     {39'd0, busy}, 40'd0);
    check("ign_response", response,      40'h01);
    check("ign_r1",       {32'd0, r1},   40'h01);
    do_start(1'b0);
    check("b2b_busy",     {39'd0, busy}, 40'd1);
    check("b2b_cleared",  response,      40'd0);

    // Reset mid-shift
    SDin = 1'b0;
    tick();
    send_head(40'hFF, 5);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy",     {39'd0, busy},    40'd0);
    check("rst_mid_done",     {39'd0, done},    40'd0);
    check("rst_mid_response", response,         40'd0);
    check("rst_mid_timeout",  {39'd0, timeout}, 40'd0);
    tick();
    tick();
    #1;
    reset = 1'b1;
    tick();
    check("rst_mid_no_done", {39'd0, done}, 40'd0);
    do_start(1'b0);
    idle_high(2);
    send_head(40'h01, 8);
    send_last(40'h01);
    check("post_rst_done",     {39'd0, done}, 40'd1);
    check("post_rst_response", response,      40'h01);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_receive_sd_response
`default_nettype wire
